// File: rtl/arb_pkg.sv
// Shared definitions for the 8-way round-robin arbiter: sizes, FSM states
// and a one-hot decode helper.
package arb_pkg;

  localparam int unsigned N_REQ = 8;
  localparam int unsigned IDX_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  function automatic logic [N_REQ-1:0] idx2onehot(input logic [IDX_W-1:0] idx);
    logic [N_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority 8-to-3 encoder: the first set request bit
// at or after ptr (wrapping 7 -> 0) wins.
module rr_pick
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             hit
);

  logic [N_REQ-1:0] rot;
  logic [IDX_W-1:0] off;

  // rot[i] holds req[(i + ptr) mod 8], so bit 0 is the highest-priority requester
  always_comb begin
    rot = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      logic [IDX_W-1:0] j;
      j      = IDX_W'(i) + ptr;
      rot[i] = req[j];
    end
  end

  always_comb begin
    logic found;
    found = 1'b0;
    off   = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (rot[i] && !found) begin
        off   = IDX_W'(i);
        found = 1'b1;
      end
    end
  end

  assign hit = |req;
  assign idx = hit ? (off + ptr) : '0;

endmodule

// File: rtl/round_robin_arbiter_8.sv
// Round-robin arbiter for 8 requesters with hold limit, bubble-free handoff
// and registered one-hot/encoded grant outputs.
module round_robin_arbiter_8
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             timeout
);

  localparam int unsigned     CNT_W    = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_HOLD - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;

  logic [IDX_W-1:0] owner_next;
  logic [IDX_W-1:0] pick_ptr;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_hit;
  logic             owner_req;
  logic             at_limit;
  logic             release_now;

  // One encoder serves both states: in GRANT it only matters on release,
  // where the pointer it needs is the post-release one (owner + 1).
  assign owner_next = idx_q + IDX_W'(1);
  assign pick_ptr   = (state_q == GRANT) ? owner_next : ptr_q;

  rr_pick u_pick (
    .req (req),
    .ptr (pick_ptr),
    .idx (pick_idx),
    .hit (pick_hit)
  );

  assign owner_req   = req[idx_q];
  assign at_limit    = (cnt_q == CNT_LAST);
  assign release_now = done || !owner_req || at_limit;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    gnt_d     = gnt_q;
    idx_d     = idx_q;
    valid_d   = valid_q;
    timeout_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_hit) begin
          state_d = GRANT;
          gnt_d   = idx2onehot(pick_idx);
          idx_d   = pick_idx;
          valid_d = 1'b1;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (release_now) begin
          ptr_d     = owner_next;
          timeout_d = at_limit && !done && owner_req;
          cnt_d     = '0;
          if (pick_hit) begin
            gnt_d = idx2onehot(pick_idx);
            idx_d = pick_idx;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
            idx_d   = '0;
            valid_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        idx_d   = '0;
        valid_d = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      cnt_q     <= '0;
      gnt_q     <= '0;
      idx_q     <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      gnt_q     <= gnt_d;
      idx_q     <= idx_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = idx_q;
  assign gnt_valid = valid_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_round_robin_arbiter_8.sv
// Directed-vector bench for round_robin_arbiter_8 with hand-computed expectations.
module tb_round_robin_arbiter_8;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  round_robin_arbiter_8 #(.MAX_HOLD(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Checks all four outputs; the expected one-hot is derived from the expected index.
  task automatic check_out(input string tag, input logic vld, input logic [2:0] idx,
                           input logic tmo);
    logic [7:0] exp_gnt;
    exp_gnt = vld ? (8'h01 << idx) : 8'h00;
    check({tag, ".valid"},   {31'd0, gnt_valid}, {31'd0, vld});
    check({tag, ".idx"},     {29'd0, gnt_idx},   vld ? {29'd0, idx} : 32'd0);
    check({tag, ".gnt"},     {24'd0, gnt},       {24'd0, exp_gnt});
    check({tag, ".timeout"}, {31'd0, timeout},   {31'd0, tmo});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 8'h00;
    done  = 1'b0;
    #1;
    check_out("in_reset", 1'b0, 3'd0, 1'b0);
    #20;
    rst_n = 1'b1;

    // Reset idle
    for (int i = 0; i < 10; i++) begin
      tick();
      check_out($sformatf("idle%0d", i), 1'b0, 3'd0, 1'b0);
    end

    // Single requester, done on third grant cycle
    req = 8'h01;
    tick();
    check_out("single.c1", 1'b1, 3'd0, 1'b0);
    tick();
    check_out("single.c2", 1'b1, 3'd0, 1'b0);
    tick();
    check_out("single.c3", 1'b1, 3'd0, 1'b0);
    done = 1'b1;
    req  = 8'h00;
    tick();
    done = 1'b0;
    check_out("single.idle", 1'b0, 3'd0, 1'b0);
    // ptr is now 1, so requester 1 beats requester 0
    req = 8'h03;
    tick();
    check_out("single.ptr1", 1'b1, 3'd1, 1'b0);
    req = 8'h00;
    tick();
    check_out("single.rel", 1'b0, 3'd0, 1'b0);

    // Full rotation from ptr=0
    #2 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    req  = 8'hFF;
    done = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      check_out($sformatf("rot%0d", i), 1'b1, 3'(i % 8), 1'b0);
    end
    req  = 8'h00;
    done = 1'b0;
    tick();
    check_out("rot.idle", 1'b0, 3'd0, 1'b0);

    // Wrap priority: grant 5 leaves ptr=6, so 0 wins over 5
    req = 8'h20;
    tick();
    check_out("wrap.g5", 1'b1, 3'd5, 1'b0);
    req = 8'h00;
    tick();
    check_out("wrap.idle", 1'b0, 3'd0, 1'b0);
    req = 8'h21;
    tick();
    check_out("wrap.g0", 1'b1, 3'd0, 1'b0);
    req = 8'h00;
    tick();
    check_out("wrap.idle2", 1'b0, 3'd0, 1'b0);

    // Timeout after exactly 16 cycles, sole requester re-granted
    req = 8'h08;
    tick();
    for (int k = 1; k <= 16; k++) begin
      check_out($sformatf("hold%0d", k), 1'b1, 3'd3, 1'b0);
      if (k < 16) tick();
    end
    tick();
    check_out("timeout", 1'b1, 3'd3, 1'b1);
    // Second grant: done on cycle 16 suppresses timeout
    for (int k = 2; k <= 16; k++) begin
      tick();
      check_out($sformatf("hold2_%0d", k), 1'b1, 3'd3, 1'b0);
    end
    done = 1'b1;
    tick();
    done = 1'b0;
    check_out("done_limit", 1'b1, 3'd3, 1'b0);
    tick();
    check_out("done_limit.c2", 1'b1, 3'd3, 1'b0);

    // Non-owner request changes leave the current grant alone
    req = 8'hF8;
    tick();
    check_out("ignore", 1'b1, 3'd3, 1'b0);
    done = 1'b1;
    tick();
    done = 1'b0;
    check_out("handoff4", 1'b1, 3'd4, 1'b0);

    // Owner 4 drops its request: ptr=5, requester 6 is next
    req = 8'h40;
    tick();
    check_out("grant6", 1'b1, 3'd6, 1'b0);

    // Asynchronous reset mid-grant, then ptr=0 favours 2 over 6
    #2 rst_n = 1'b0;
    #1;
    check_out("async_rst", 1'b0, 3'd0, 1'b0);
    req = 8'h44;
    #1 rst_n = 1'b1;
    tick();
    check_out("post_rst", 1'b1, 3'd2, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/round_robin_arbiter_8.md
# round_robin_arbiter_8

Round-robin arbiter that shares one resource among 8 requesters. Each cycle it picks a winner with a rotating-priority 8-to-3 encode, holds the grant until the owner finishes, drops its request or hits a hold limit, then re-arbitrates without a bubble. It sits in front of any shared datapath that the 8-to-3 encoder family feeds. It produces a one-hot grant plus the encoded index and a valid flag.

## Interface
- `MAX_HOLD`, default 16, is the maximum number of consecutive cycles one grant may last. Legal range is 2..256.
- `clk`: input, 1 bit, rising-edge clock.
- `rst_n`: input, 1 bit, asynchronous active-low reset.
- `req`: input, 8 bits, request vector; bit i is requester i.
- `done`: input, 1 bit, owner signals it is finished; sampled only while `gnt_valid`=1.
- `gnt`: output, 8 bits, one-hot grant; all zero when idle.
- `gnt_idx`: output, 3 bits, encoded owner index; 0 when idle.
- `gnt_valid`: output, 1 bit, a grant is active.
- `timeout`: output, 1 bit, one-cycle pulse when a grant is cut off by `MAX_HOLD`.

## Operation
- **Reset:** applies asynchronously on `rst_n`=0, including mid-grant. Required values:
  - `gnt`=0, `gnt_idx`=0, `gnt_valid`=0, `timeout`=0.
  - Pointer `ptr`=0, hold counter=0, state IDLE.
- **States:** IDLE and GRANT. All outputs are registered.
- **Pick function:** the first set bit of `req` searching `ptr`, `ptr`+1, … modulo 8 (7 wraps to 0). It also returns a hit flag.
- **IDLE:**
  - If the pick hits, register `gnt`, `gnt_idx` and `gnt_valid`=1, clear the counter, and go to GRANT.
  - Otherwise stay in IDLE.
- **GRANT:** the owner is `gnt_idx`. Release happens when any of these holds:
  - `done`=1, or
  - `req[owner]`=0, or
  - counter = `MAX_HOLD`-1.
- **On release:**
  - `ptr` ← owner+1 mod 8, so the owner becomes lowest priority.
  - Re-run the pick with the new pointer on the same-cycle `req`.
  - On a hit, load the new grant directly and stay in GRANT with the counter cleared.
  - On no hit, clear the outputs and go to IDLE.
- **Without release:** the grant holds and the counter increments.
- **`timeout`:** asserted for one cycle, registered alongside the release, only when the release cause is the counter limit and `done`=0 and `req[owner]`=1.
  - `done` has priority, so simultaneous `done` and limit gives `timeout`=0.
- **Re-grant of the same requester:** allowed only when no other requester is active at the release cycle (for example, sole requester after timeout).
- **Ignored input changes:** changes in `req` of non-owners while in GRANT do not affect the current grant.
- **Counter width:** clog2(`MAX_HOLD`) bits. It never exceeds `MAX_HOLD`-1.

## Timing
- Latency is one cycle: a request sampled at edge n in IDLE gives `gnt_valid`=1 after edge n.
- Back-to-back handoff:
  - Release evaluated at edge n gives the new owner's grant after edge n.
  - There is no idle cycle between owners.
- A grant lasts at least 1 and at most `MAX_HOLD` cycles.
- `timeout` is high during the cycle after the final granted cycle of the timed-out owner, coincident with the next grant or with idle.
- `gnt`, `gnt_idx` and `gnt_valid` always change together. `gnt` equals 1<<`gnt_idx` whenever `gnt_valid`=1.

## Structure
- Shared package `arb_pkg` holds:
  - `N_REQ`=8 and `IDX_W`=3.
  - The state enum {IDLE, GRANT}.
- Sub-module `rr_pick`: combinational rotating-priority 8-to-3 encoder.
  - Inputs: `req[7:0]`, `ptr[2:0]`.
  - Outputs: `idx[2:0]`, `hit`.
  - Implementation: rotate right by `ptr`, fixed LSB-first encode, add `ptr` mod 8.
- Top level: state register, pointer, hold counter, output registers.

## Test plan
- **Reset idle:** `rst_n`=0 then 1 with `req`=0 → all outputs 0 for 10 cycles.
- **Single requester:**
  - `req`=8'b0000_0001 → `gnt`=8'h01, `gnt_idx`=0 and `gnt_valid`=1 one cycle later.
  - `done` pulse on the 3rd grant cycle → idle next cycle, `ptr`=1.
- **Full rotation:** `req`=8'hFF with `done`=1 every cycle → `gnt_idx` runs 0,1,…,7,0 with `gnt_valid` continuously 1.
- **Wrap priority:** after a grant to 5 (`ptr`=6), `req`=8'b0010_0001 → grant goes to 0, not 5.
- **Timeout:** `MAX_HOLD`=16, `req`=8'b0000_1000 held, `done`=0:
  - Grant to 3 for exactly 16 cycles.
  - Then `timeout`=1 for one cycle while 3 is re-granted.
  - Repeat with `done` on cycle 16 → `timeout`=0.
- **Mid-grant reset:** `rst_n`=0 while `gnt_idx`=6 → outputs 0 immediately, without a clock edge. After release with `req`=8'b0100_0100, the first grant goes to 2 because `ptr` was reset to 0.
